i2c_bus_recovery: RTL and testbench
===================================

# i2c_bus_recovery

Parametrised, multi-channel I2C bus recovery engine. It is the successor of the single-channel SCL toggler. Per channel, it clocks SCL until the slave releases SDA, bounded by a pulse limit. It then generates a proper STOP and reports done, busy and fail status. It sits between the board-reset/control registers and the open-drain pad muxes of each I2C bus. Lines are pre-synchronised to `clk` at top level.

## Interface
- `CHANNELS`, 1: number of independent I2C buses.
- `MAX_PULSES`, 9: maximum SCL low pulses per recovery before declaring failure (≥1).
- `STRETCH_TIMEOUT`, 0: `ce` ticks SCL may be held low by a slave during a high phase before abort; 0 means wait forever.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `ce`  in  1  tick enable; one tick = one SCL half-period; shared by all channels.
- `start`  in  CHANNELS  per-channel recovery request, level-sampled every `clk` (not `ce`-gated).
- `sda`  in  CHANNELS  synchronised SDA line level.
- `scl`  in  CHANNELS  synchronised SCL line level (for stretch detection).
- `sda_out`  out  CHANNELS  SDA drive; 1 = release, 0 = pull low.
- `scl_out`  out  CHANNELS  SCL drive; 1 = release, 0 = pull low.
- `busy`  out  CHANNELS  channel is not IDLE.
- `done`  out  CHANNELS  one-`clk` pulse on completion (success or fail).
- `fail`  out  CHANNELS  sticky; set on pulse-limit or stretch-timeout abort; cleared by `start` or `rst`.

## Operation
- Each channel has an independent FSM, a pulse counter of width $clog2(MAX_PULSES+1) and a stretch counter of width $clog2(STRETCH_TIMEOUT+1).
- Outputs are decoded from state as (scl_out, sda_out):
  - IDLE (1,1), SCL_HIGH (1,1), SCL_LOW (0,1)
  - STOP_SCL0 (0,1), STOP_SDA0 (0,0), STOP_SCL1 (1,0)
- `start[i]` in any state, on any `clk`: go to SCL_HIGH, clear the pulse counter, the stretch counter and `fail[i]`. `start` has priority over `ce`. A start during recovery restarts from scratch.
- All other transitions happen only on cycles with `ce`=1:
  - SCL_HIGH, `scl[i]`=0 (stretch): stay and increment the stretch counter. If STRETCH_TIMEOUT≠0 and the counter reaches STRETCH_TIMEOUT: go to IDLE, set `fail`, pulse `done`.
  - SCL_HIGH, `scl[i]`=1, `sda[i]`=1: go to STOP_SCL0.
  - SCL_HIGH, `scl[i]`=1, `sda[i]`=0, pulse counter = MAX_PULSES: go to IDLE, set `fail`, pulse `done`. No STOP is sent.
  - SCL_HIGH otherwise: go to SCL_LOW.
  - SCL_LOW: increment the pulse counter, clear the stretch counter, go to SCL_HIGH.
  - STOP_SCL0 → STOP_SDA0 → STOP_SCL1 → IDLE; the transition into IDLE pulses `done` with `fail`=0.
- SDA is sampled only in SCL_HIGH with SCL actually high. If SDA is already high at the first sample, zero SCL pulses are issued.
- A channel never pulls SDA low while SCL is high, except in STOP_SCL1, which is entered from STOP_SDA0, so SDA falls while SCL is low.

## Timing
- Reset values: every channel IDLE, `scl_out`=`sda_out`=all ones, `busy`=`done`=`fail`=0, counters 0.
- `rst` mid-operation: lines released on the next cycle, no `done` pulse, `fail` cleared.
- All outputs are registered or decoded directly from state registers; there is no combinational path from inputs to outputs.
- `busy` is high in the cycle after `start` is sampled. It falls in the same cycle `done` rises.
- `done` is high for exactly one `clk`, in the first IDLE cycle.
- With `ce`=1 continuously and SDA high:
  - `start` sampled at edge E0; SCL_HIGH after E0, STOP_SCL0 after E1, STOP_SDA0 after E2, STOP_SCL1 after E3, IDLE with `done` after E4.
  - Each additional SCL pulse adds 2 cycles.
- With a slower `ce`, every non-IDLE state lasts until the next `ce`. The `start` response remains one `clk`.
- Channels share only `ce`. Simultaneous starts on several channels proceed in lockstep and independently.

## Test plan
All scenarios use CHANNELS=2, MAX_PULSES=9, STRETCH_TIMEOUT=4, `ce`=1.
- SDA high, start[0] 1 cycle → no SCL low before STOP; (scl,sda) sequence 11,01,00,10,11; `done[0]` 4 cycles after start; `fail[0]`=0; channel 1 stays 11.
- Slave releases SDA after 3rd SCL low pulse → exactly 3 SCL low pulses, then STOP, `done`, `fail`=0.
- SDA stuck low → exactly 9 SCL low pulses, no STOP, lines released, `done` pulse, `fail[0]`=1 held until next start.
- `scl[0]` held low 2 ticks in SCL_HIGH → recovery waits 2 extra cycles and completes normally. Held low 4 ticks → abort, `fail`=1, `done` pulse.
- start[0] re-asserted after 5 pulses with SDA stuck → counter restarts and a further 9 pulses are issued. start[1] concurrently → channel 1 is independent.
- `rst` asserted during STOP_SDA0 → next cycle all outputs released, `busy`=0, no `done`. Then `ce` every 4th cycle → each state lasts 4 `clk`.

Source files
------------

// File: rtl/i2c_bus_recovery.sv
// Multi-channel I2C bus recovery: clocks SCL until the slave frees SDA (bounded by
// MAX_PULSES), then drives a STOP. Each channel runs its own FSM and shares only ce.
module i2c_bus_recovery #(
  parameter int CHANNELS        = 1,
  parameter int MAX_PULSES      = 9,
  parameter int STRETCH_TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] sda,
  input  logic [CHANNELS-1:0] scl,
  output logic [CHANNELS-1:0] sda_out,
  output logic [CHANNELS-1:0] scl_out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done,
  output logic [CHANNELS-1:0] fail
);

  localparam int PW = $clog2(MAX_PULSES + 1);
  localparam int SW = (STRETCH_TIMEOUT > 0) ? $clog2(STRETCH_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SCL_HIGH,
    SCL_LOW,
    STOP_SCL0,
    STOP_SDA0,
    STOP_SCL1
  } state_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t        state_q, state_d;
    logic [PW-1:0] pulse_q, pulse_d;
    logic [SW-1:0] stretch_q, stretch_d;
    logic [SW:0]   stretch_inc;
    logic          done_q, done_d;
    logic          fail_q, fail_d;

    assign stretch_inc = {1'b0, stretch_q} + (SW + 1)'(1);

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= IDLE;
        pulse_q   <= '0;
        stretch_q <= '0;
        done_q    <= 1'b0;
        fail_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        pulse_q   <= pulse_d;
        stretch_q <= stretch_d;
        done_q    <= done_d;
        fail_q    <= fail_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      pulse_d   = pulse_q;
      stretch_d = stretch_q;
      done_d    = 1'b0;
      fail_d    = fail_q;
      if (start[g]) begin
        state_d   = SCL_HIGH;
        pulse_d   = '0;
        stretch_d = '0;
        fail_d    = 1'b0;
      end else if (ce) begin
        case (state_q)
          IDLE: state_d = IDLE;
          SCL_HIGH: begin
            // SDA is only trusted once SCL has really gone high on the wire
            if (!scl[g]) begin
              stretch_d = stretch_inc[SW-1:0];
              if ((STRETCH_TIMEOUT != 0) && (stretch_inc == (SW + 1)'(STRETCH_TIMEOUT))) begin
                state_d = IDLE;
                fail_d  = 1'b1;
                done_d  = 1'b1;
              end
            end else if (sda[g]) begin
              state_d = STOP_SCL0;
            end else if (pulse_q == PW'(MAX_PULSES)) begin
              state_d = IDLE;
              fail_d  = 1'b1;
              done_d  = 1'b1;
            end else begin
              state_d = SCL_LOW;
            end
          end
          SCL_LOW: begin
            pulse_d   = pulse_q + PW'(1);
            stretch_d = '0;
            state_d   = SCL_HIGH;
          end
          STOP_SCL0: state_d = STOP_SDA0;
          STOP_SDA0: state_d = STOP_SCL1;
          STOP_SCL1: begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    assign scl_out[g] = !(state_q inside {SCL_LOW, STOP_SCL0, STOP_SDA0});
    assign sda_out[g] = !(state_q inside {STOP_SDA0, STOP_SCL1});
    assign busy[g]    = (state_q != IDLE);
    assign done[g]    = done_q;
    assign fail[g]    = fail_q;
  end

endmodule

// File: tb/tb_i2c_bus_recovery.sv
// Bench for i2c_bus_recovery: slave/wire model per channel, outcomes compared against
// closed-form pulse count, fail flag and completion latency.
module tb_i2c_bus_recovery;
  localparam int CH   = 2;
  localparam int MAXP = 9;
  localparam int STO  = 4;

  logic          clk = 1'b0;
  logic          rst, ce;
  logic [CH-1:0] start, sda, scl;
  logic [CH-1:0] sda_out, scl_out, busy, done, fail;

  i2c_bus_recovery #(
    .CHANNELS(CH), .MAX_PULSES(MAXP), .STRETCH_TIMEOUT(STO)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .sda(sda), .scl(scl),
    .sda_out(sda_out), .scl_out(scl_out), .busy(busy), .done(done), .fail(fail)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ce_period = 1;
  int ce_ph = 0;

  // slave model: SDA held low until k_rel SCL falls seen; SCL stretched while cyc < hold_until
  int   k_rel[CH], hold_until[CH], start_cyc[CH];
  int   falls[CH], stop_seen[CH], done_cnt[CH], done_n[CH], viol[CH];
  int   dur01[CH], dur00[CH], dur10[CH], active[CH], idle_bad[CH];
  logic busy_at_done[CH], fail_at_done[CH], prev_scl[CH], prev_sda[CH];
  logic [1:0] seq_log[CH][8];

  function automatic int exp_pulses(input int k, input int s);
    if (s >= STO) return 0;
    return (k > MAXP) ? MAXP : k;
  endfunction

  function automatic logic exp_fail(input int k, input int s);
    return (s >= STO) || (k > MAXP);
  endfunction

  function automatic int exp_lat(input int k, input int s);
    if (s >= STO) return STO;
    if (k > MAXP) return 2 * MAXP + 1 + s;
    return 2 * k + 4 + s;
  endfunction

  task automatic step();
    int n;
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < CH; c++) begin
      n = cyc - start_cyc[c];
      if (n >= 0 && n < 8) seq_log[c][n] = {scl_out[c], sda_out[c]};
      if (prev_scl[c] && !scl_out[c]) falls[c]++;
      if (!scl_out[c] && !sda_out[c]) stop_seen[c] = 1;
      if (prev_scl[c] && scl_out[c] && prev_sda[c] && !sda_out[c]) viol[c]++;
      if (busy[c]) active[c]++;
      if (!busy[c] && {scl_out[c], sda_out[c]} != 2'b11) idle_bad[c]++;
      if (busy[c] && {scl_out[c], sda_out[c]} == 2'b01) dur01[c]++;
      if (busy[c] && {scl_out[c], sda_out[c]} == 2'b00) dur00[c]++;
      if (busy[c] && {scl_out[c], sda_out[c]} == 2'b10) dur10[c]++;
      if (done[c]) begin
        if (done_cnt[c] == 0) begin
          done_n[c]       = n;
          busy_at_done[c] = busy[c];
          fail_at_done[c] = fail[c];
        end
        done_cnt[c]++;
      end
      prev_scl[c] = scl_out[c];
      prev_sda[c] = sda_out[c];
      sda[c] = sda_out[c] & (falls[c] >= k_rel[c]);
      scl[c] = scl_out[c] & !(cyc < hold_until[c]);
    end
    ce    = (ce_ph == ce_period - 1);
    ce_ph = (ce_ph + 1) % ce_period;
  endtask

  task automatic kick(input logic [1:0] mask, input int k0, input int s0, input int k1, input int s1);
    for (int c = 0; c < CH; c++) begin
      if (mask[c]) begin
        k_rel[c]      = (c == 0) ? k0 : k1;
        hold_until[c] = cyc + 1 + ((c == 0) ? s0 : s1);
        start_cyc[c]  = cyc + 1;
        falls[c] = 0; stop_seen[c] = 0; done_cnt[c] = 0; done_n[c] = -1; viol[c] = 0;
        dur01[c] = 0; dur00[c] = 0; dur10[c] = 0; active[c] = 0;
        for (int n = 0; n < 8; n++) seq_log[c][n] = 2'b00;
      end
    end
    start = mask;
    step();
    start = '0;
  endtask

  task automatic wait_done(input logic [1:0] mask, input int budget, output logic timed_out);
    int i;
    i = 0;
    while (((mask[0] && done_cnt[0] == 0) || (mask[1] && done_cnt[1] == 0)) && i < budget) begin
      step();
      i++;
    end
    timed_out = (mask[0] && done_cnt[0] == 0) || (mask[1] && done_cnt[1] == 0);
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = '0; sda = '1; scl = '1; ce = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (scl_out !== 2'b11) begin failures++; $display("FAIL reset_scl_out got=%b exp=11", scl_out); end
    checks++; if (sda_out !== 2'b11) begin failures++; $display("FAIL reset_sda_out got=%b exp=11", sda_out); end
    checks++; if (busy !== 2'b00) begin failures++; $display("FAIL reset_busy got=%b exp=00", busy); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", done); end
    checks++; if (fail !== 2'b00) begin failures++; $display("FAIL reset_fail got=%b exp=00", fail); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_sda_high();
    logic to;
    logic [9:0] got;
    active[1] = 0;
    kick(2'b01, 0, 0, 0, 0);
    wait_done(2'b01, 40, to);
    got = {seq_log[0][0], seq_log[0][1], seq_log[0][2], seq_log[0][3], seq_log[0][4]};
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL simple_timeout got=%b exp=0", to); end
    checks++; if (got !== 10'b11_01_00_10_11) begin failures++; $display("FAIL simple_seq got=%b exp=1101001011", got); end
    checks++; if (done_n[0] != 4) begin failures++; $display("FAIL simple_latency got=%0d exp=4", done_n[0]); end
    checks++; if (fail_at_done[0] !== 1'b0) begin failures++; $display("FAIL simple_fail got=%b exp=0", fail_at_done[0]); end
    checks++; if (busy_at_done[0] !== 1'b0) begin failures++; $display("FAIL simple_busy_at_done got=%b exp=0", busy_at_done[0]); end
    checks++; if (done_cnt[0] != 1) begin failures++; $display("FAIL simple_done_width got=%0d exp=1", done_cnt[0]); end
    checks++; if (falls[0] - stop_seen[0] != 0) begin failures++; $display("FAIL simple_pulses got=%0d exp=0", falls[0] - stop_seen[0]); end
    checks++; if (active[1] != 0) begin failures++; $display("FAIL simple_ch1_busy got=%0d exp=0", active[1]); end
  endtask

  task automatic test_recovery_table();
    logic to;
    int k, s;
    for (int i = 0; i < 12; i++) begin
      case (i)
        0: begin k = 3;  s = 0; end
        1: begin k = 99; s = 0; end
        2: begin k = 0;  s = 2; end
        3: begin k = 0;  s = 4; end
        4: begin k = 5;  s = 3; end
        default: begin k = int'($urandom_range(0, 12)); s = int'($urandom_range(0, 5)); end
      endcase
      kick(2'b01, k, s, 0, 0);
      wait_done(2'b01, 80, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL rec_timeout k=%0d s=%0d got=%b exp=0", k, s, to); end
      checks++; if (falls[0] - stop_seen[0] != exp_pulses(k, s)) begin failures++;
        $display("FAIL rec_pulses k=%0d s=%0d got=%0d exp=%0d", k, s, falls[0] - stop_seen[0], exp_pulses(k, s)); end
      checks++; if (fail_at_done[0] !== exp_fail(k, s)) begin failures++;
        $display("FAIL rec_fail k=%0d s=%0d got=%b exp=%b", k, s, fail_at_done[0], exp_fail(k, s)); end
      checks++; if (done_n[0] != exp_lat(k, s)) begin failures++;
        $display("FAIL rec_latency k=%0d s=%0d got=%0d exp=%0d", k, s, done_n[0], exp_lat(k, s)); end
      checks++; if ((stop_seen[0] != 0) !== !exp_fail(k, s)) begin failures++;
        $display("FAIL rec_stop k=%0d s=%0d got=%0d exp=%b", k, s, stop_seen[0], !exp_fail(k, s)); end
      checks++; if (done_cnt[0] != 1 || busy_at_done[0] !== 1'b0) begin failures++;
        $display("FAIL rec_done_pulse k=%0d s=%0d got=%0d/%b exp=1/0", k, s, done_cnt[0], busy_at_done[0]); end
      checks++; if (viol[0] != 0) begin failures++; $display("FAIL rec_sda_fall_scl_high got=%0d exp=0", viol[0]); end
    end
  endtask

  task automatic test_fail_sticky();
    logic to;
    kick(2'b01, 99, 0, 0, 0);
    wait_done(2'b01, 60, to);
    repeat (6) step();
    checks++; if (to !== 1'b0 || fail[0] !== 1'b1) begin failures++; $display("FAIL sticky_hold got=%b exp=1", fail[0]); end
    checks++; if (done[0] !== 1'b0) begin failures++; $display("FAIL sticky_done got=%b exp=0", done[0]); end
    kick(2'b01, 0, 0, 0, 0);
    checks++; if (fail[0] !== 1'b0 || busy[0] !== 1'b1) begin failures++;
      $display("FAIL sticky_clear got=fail %b busy %b exp=fail 0 busy 1", fail[0], busy[0]); end
    wait_done(2'b01, 40, to);
    checks++; if (to !== 1'b0 || fail_at_done[0] !== 1'b0) begin failures++; $display("FAIL sticky_rerun got=%b exp=0", fail_at_done[0]); end
  endtask

  task automatic test_restart();
    logic to;
    int i, k1;
    kick(2'b01, 99, 0, 0, 0);
    i = 0;
    while (falls[0] < 5 && i < 40) begin step(); i++; end
    checks++; if (falls[0] != 5) begin failures++; $display("FAIL restart_reach5 got=%0d exp=5", falls[0]); end
    k1 = int'($urandom_range(0, 12));
    kick(2'b11, 99, 0, k1, 0);
    wait_done(2'b11, 80, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL restart_timeout got=%b exp=0", to); end
    checks++; if (falls[0] - stop_seen[0] != MAXP) begin failures++; $display("FAIL restart_pulses got=%0d exp=%0d", falls[0] - stop_seen[0], MAXP); end
    checks++; if (fail_at_done[0] !== 1'b1 || done_n[0] != 2 * MAXP + 1) begin failures++;
      $display("FAIL restart_fail_lat got=%b/%0d exp=1/%0d", fail_at_done[0], done_n[0], 2 * MAXP + 1); end
    checks++; if (falls[1] - stop_seen[1] != exp_pulses(k1, 0)) begin failures++;
      $display("FAIL ch1_pulses k=%0d got=%0d exp=%0d", k1, falls[1] - stop_seen[1], exp_pulses(k1, 0)); end
    checks++; if (fail_at_done[1] !== exp_fail(k1, 0) || done_n[1] != exp_lat(k1, 0)) begin failures++;
      $display("FAIL ch1_fail_lat k=%0d got=%b/%0d exp=%b/%0d", k1, fail_at_done[1], done_n[1], exp_fail(k1, 0), exp_lat(k1, 0)); end
  endtask

  task automatic test_rst_and_slow_ce();
    logic to;
    int i;
    kick(2'b01, 0, 0, 0, 0);
    i = 0;
    while ({scl_out[0], sda_out[0]} != 2'b00 && i < 10) begin step(); i++; end
    checks++; if ({scl_out[0], sda_out[0]} !== 2'b00) begin failures++; $display("FAIL rst_reach_sda0 got=%b exp=00", {scl_out[0], sda_out[0]}); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({scl_out[0], sda_out[0], busy[0], done[0], fail[0]} !== 5'b11000) begin failures++;
      $display("FAIL rst_release got=%b exp=11000", {scl_out[0], sda_out[0], busy[0], done[0], fail[0]}); end
    repeat (6) step();
    checks++; if (done_cnt[0] != 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", done_cnt[0]); end
    ce_period = 4; ce_ph = 0;
    kick(2'b01, 0, 0, 0, 0);
    checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL slow_start_resp got=%b exp=1", busy[0]); end
    wait_done(2'b01, 80, to);
    checks++; if (to !== 1'b0 || fail_at_done[0] !== 1'b0 || done_cnt[0] != 1) begin failures++;
      $display("FAIL slow_complete got=%b/%b/%0d exp=0/0/1", to, fail_at_done[0], done_cnt[0]); end
    checks++; if (dur01[0] != 4 || dur00[0] != 4 || dur10[0] != 4) begin failures++;
      $display("FAIL slow_state_len got=%0d/%0d/%0d exp=4/4/4", dur01[0], dur00[0], dur10[0]); end
    ce_period = 1; ce_ph = 0;
    step();
  endtask

  initial begin
    for (int c = 0; c < CH; c++) begin
      k_rel[c] = 0; hold_until[c] = 0; start_cyc[c] = 1 << 20;
      falls[c] = 0; stop_seen[c] = 0; done_cnt[c] = 0; done_n[c] = -1; viol[c] = 0;
      dur01[c] = 0; dur00[c] = 0; dur10[c] = 0; active[c] = 0; idle_bad[c] = 0;
      busy_at_done[c] = 1'b0; fail_at_done[c] = 1'b0; prev_scl[c] = 1'b1; prev_sda[c] = 1'b1;
    end
    test_reset();
    test_sda_high();
    test_recovery_table();
    test_fail_sticky();
    test_restart();
    test_rst_and_slow_ce();
    checks++; if (idle_bad[0] + idle_bad[1] != 0) begin failures++;
      $display("FAIL idle_lines_released got=%0d exp=0", idle_bad[0] + idle_bad[1]); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
